// File: rtl/fixedpt_mult_pkg.sv
// fixedpt_mult_pkg: shared state encoding and sizing helpers for the iterative fixed-point multiplier
package fixedpt_mult_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic int iter_count(input int n, input int k);
        return n / k;
    endfunction

    function automatic int cnt_width(input int n, input int k);
        return $clog2(n / k + 1);
    endfunction
endpackage

// File: rtl/fixedpt_mult_digit_pp.sv
// fixedpt_mult_digit_pp: multiplicand times one k-bit digit; the last digit is taken as signed
module fixedpt_mult_digit_pp #(
    parameter int n = 32,
    parameter int k = 2
) (
    input  logic [2*n-1:0] i_mcand,
    input  logic [k-1:0]   i_digit,
    input  logic           i_last,
    output logic [2*n-1:0] o_pp
);
    logic [2*n-1:0] w_digit;

    // Only the final digit carries the sign of b, so its top bit weighs -2^(k-1).
    assign w_digit = (2*n)'($signed({i_last & i_digit[k-1], i_digit}));
    assign o_pp    = i_mcand * w_digit;
endmodule

// File: rtl/fixedpt_iter_mult_radix.sv
// fixedpt_iter_mult_radix: c = (a*b) >>> d, k multiplier bits per cycle, val/rdy on both sides
// Define FIXEDPT_MULT_ROUND_EN for round-half-up instead of truncation toward -inf.
module fixedpt_iter_mult_radix
    import fixedpt_mult_pkg::*;
#(
    parameter int n = 32,
    parameter int d = 16,
    parameter int k = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           recv_val,
    output logic           recv_rdy,
    input  logic [2*n-1:0] recv_msg,
    output logic           send_val,
    input  logic           send_rdy,
    output logic [n-1:0]   send_msg
);
    localparam int ITER = iter_count(n, k);
    localparam int CW = cnt_width(n, k);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt;
    logic [2*n-1:0] r_mcand, r_acc, w_pp, w_acc_rnd;
    logic [n-1:0]   r_mplier, w_res;
    logic           w_last, w_accept;

    assign w_last   = r_cnt == LAST;
    assign w_accept = recv_val & recv_rdy;

    fixedpt_mult_digit_pp #(.n(n), .k(k)) u_pp (
        .i_mcand(r_mcand),
        .i_digit(r_mplier[k-1:0]),
        .i_last (w_last),
        .o_pp   (w_pp)
    );

    always_comb begin
        w_next   = r_state;
        recv_rdy = 1'b0;
        send_val = 1'b0;
        case (r_state)
            IDLE: begin
                recv_rdy = 1'b1;
                w_next   = recv_val ? CALC : IDLE;
            end
            CALC: w_next = w_last ? DONE : CALC;
            DONE: begin
                send_val = 1'b1;
                recv_rdy = send_rdy;
                w_next   = !send_rdy ? DONE : (recv_val ? CALC : IDLE);
            end
            default: w_next = IDLE;
        endcase
    end

`ifdef FIXEDPT_MULT_ROUND_EN
    generate
        if (d == 0) begin : g_rnd
            assign w_acc_rnd = r_acc;
        end else begin : g_rnd
            assign w_acc_rnd = r_acc + ((2*n)'(1) << (d - 1));
        end
    endgenerate
`else
    assign w_acc_rnd = r_acc;
`endif

    assign w_res    = n'($signed(w_acc_rnd) >>> d);
    assign send_msg = (r_state == DONE) ? w_res : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mcand  <= {{n{recv_msg[2*n-1]}}, recv_msg[2*n-1:n]};
                r_mplier <= recv_msg[n-1:0];
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == CALC) begin
                r_acc    <= r_acc + w_pp;
                r_mcand  <= r_mcand << k;
                r_mplier <= r_mplier >> k;
                r_cnt    <= r_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fixedpt_iter_mult_radix.sv
// tb_fixedpt_iter_mult_radix: directed vectors and corner sequences on k=2, random sweep over k=1,2,4,8
module tb_fixedpt_iter_mult_radix;
    logic        clk = 1'b0;
    logic        reset;
    logic        recv_val [4];
    logic        recv_rdy [4];
    logic [63:0] recv_msg [4];
    logic        send_val [4];
    logic        send_rdy [4];
    logic [31:0] send_msg [4];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        fixedpt_iter_mult_radix #(.n(32), .d(16), .k(1 << g)) u_dut (
            .clk     (clk),
            .reset   (reset),
            .recv_val(recv_val[g]),
            .recv_rdy(recv_rdy[g]),
            .recv_msg(recv_msg[g]),
            .send_val(send_val[g]),
            .send_rdy(send_rdy[g]),
            .send_msg(send_msg[g])
        );
    end

`ifdef FIXEDPT_MULT_ROUND_EN
    localparam logic [31:0] E_HALF = 32'h0000_0001;
    localparam logic [31:0] E_NEG  = 32'h0000_0000;
`else
    localparam logic [31:0] E_HALF = 32'h0000_0000;
    localparam logic [31:0] E_NEG  = 32'hFFFF_FFFF;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
`ifdef FIXEDPT_MULT_ROUND_EN
        p = p + 64'sd32768;
`endif
        p = p >>> 16;
        return p[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic txn(input int i, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
        int w = 0;
        @(negedge clk);
        recv_msg[i] = {a, b};
        recv_val[i] = 1'b1;
        send_rdy[i] = 1'b0;
        while (!recv_rdy[i] && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        recv_val[i] = 1'b0;
        recv_msg[i] = {$urandom, $urandom};
        lat = 1;
        while (!send_val[i] && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = send_msg[i];
        send_rdy[i] = 1'b1;
        @(negedge clk);
        send_rdy[i] = 1'b0;
    endtask

    initial begin
        vec_t vecs[7];
        logic [31:0] res;
        int lat;
        int w;
        vecs[0] = '{32'h0001_8000, 32'h0002_0000, 32'h0003_0000};
        vecs[1] = '{32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000};
        vecs[2] = '{32'hFFFE_8000, 32'hFFFE_0000, 32'h0003_0000};
        vecs[3] = '{32'h0000_8000, 32'h0000_0001, E_HALF};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, E_NEG};
        vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_8000};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000};

        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            recv_val[i] = 1'b0;
            send_rdy[i] = 1'b0;
            recv_msg[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_rdy%0d", i), 64'(recv_rdy[i]), 64'd1);
            chk($sformatf("reset_val%0d", i), 64'(send_val[i]), 64'd0);
            chk($sformatf("reset_msg%0d", i), 64'(send_msg[i]), 64'd0);
        end
        reset = 1'b0;

        for (int j = 0; j < 7; j++) begin
            txn(1, vecs[j].a, vecs[j].b, res, lat);
            chk($sformatf("vec%0d_res", j), 64'(res), 64'(vecs[j].exp));
            chk($sformatf("vec%0d_lat", j), 64'(lat), 64'd17);
        end

        // Stall the consumer, then release it while new operands wait.
        @(negedge clk);
        recv_msg[1] = {32'h0001_8000, 32'h0002_0000};
        recv_val[1] = 1'b1;
        @(negedge clk);
        recv_val[1] = 1'b0;
        w = 0;
        while (!send_val[1] && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("hold_reach_done", 64'(send_val[1]), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_val", c), 64'(send_val[1]), 64'd1);
            chk($sformatf("hold%0d_msg", c), 64'(send_msg[1]), 64'h0003_0000);
            chk($sformatf("hold%0d_rdy", c), 64'(recv_rdy[1]), 64'd0);
        end
        recv_msg[1] = {32'hFFFE_8000, 32'hFFFE_0000};
        recv_val[1] = 1'b1;
        send_rdy[1] = 1'b1;
        #1;
        chk("b2b_rdy", 64'(recv_rdy[1]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        recv_val[1] = 1'b0;
        send_rdy[1] = 1'b0;
        recv_msg[1] = {$urandom, $urandom};
        chk("b2b_calc_val", 64'(send_val[1]), 64'd0);
        chk("b2b_calc_rdy", 64'(recv_rdy[1]), 64'd0);
        lat = 1;
        while (!send_val[1] && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("b2b_lat", 64'(lat), 64'd17);
        chk("b2b_res", 64'(send_msg[1]), 64'h0003_0000);
        send_rdy[1] = 1'b1;
        @(negedge clk);
        send_rdy[1] = 1'b0;

        // Abort a transaction with reset once five digits have been retired.
        @(negedge clk);
        recv_msg[1] = {32'h0001_8000, 32'h0002_0000};
        recv_val[1] = 1'b1;
        @(negedge clk);
        recv_val[1] = 1'b0;
        repeat (5) @(negedge clk);
        chk("midcalc_busy", 64'(recv_rdy[1]), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_rdy", 64'(recv_rdy[1]), 64'd1);
        chk("midrst_val", 64'(send_val[1]), 64'd0);
        chk("midrst_msg", 64'(send_msg[1]), 64'd0);
        reset = 1'b0;
        txn(1, 32'hFFFE_8000, 32'h0002_0000, res, lat);
        chk("post_rst_res", 64'(res), 64'hFFFD_0000);
        chk("post_rst_lat", 64'(lat), 64'd17);

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 300; j++) begin
                logic [31:0] a, b;
                a = $urandom;
                b = (j % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
                if (j % 8 == 1) a = {{16{a[31]}}, a[15:0]};
                txn(i, a, b, res, lat);
                chk($sformatf("k%0d_res a=%h b=%h", 1 << i, a, b), 64'(res), 64'(golden(a, b)));
                chk($sformatf("k%0d_lat", 1 << i), 64'(lat), 64'(32 / (1 << i) + 1));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
